// File: rtl/apb_regfile_slave_if.sv
// APB bus bundle for apb_regfile_slave.
// Signals: PSEL/PENABLE/PWRITE/PADDR/PWDATA (master -> slave),
//          PRDATA/PREADY/PSLVERR (slave -> master).
// Modports: master (bus initiator), slave (register file).
interface apb_regfile_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_regfile_slave.sv
// APB register-file slave with a fixed number of wait states.
// Register 0 is a read-only ID, register 1 a read-only STATUS word
// ([15:0] completed-OK count, [31:16] error count), the rest are R/W.
// Ports:
//   HCLK   - sole clock, rising edge
//   HRESET - synchronous active-high reset
//   apb    - APB slave modport (PSEL, PENABLE, PWRITE, PADDR, PWDATA in;
//            PRDATA, PREADY, PSLVERR out, all registered)
// DATA_WIDTH is expected to be at least 32 so STATUS fits.
module apb_regfile_slave #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h100),
    parameter int unsigned           NUM_REGS    = 8,
    parameter int unsigned           WAIT_STATES = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'hA5B0_0001)
) (
    input logic               HCLK,
    input logic               HRESET,
    apb_regfile_slave_if.slave apb
);

    localparam int unsigned           IDX_W   = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] SPAN    = ADDR_WIDTH'(4 * NUM_REGS);
    localparam logic [3:0]            WS_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;
    logic [15:0]           ok_cnt_q;
    logic [15:0]           err_cnt_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pready_q;
    logic                  pslverr_q;

    // Decode works on the live bus in IDLE (setup cycle) and on the latched
    // transfer otherwise, so the zero-wait case can load PRDATA at setup.
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;

    always_comb begin
        sel_addr  = (state_q == StIdle) ? apb.PADDR : addr_q;
        sel_write = (state_q == StIdle) ? apb.PWRITE : write_q;
        offset    = sel_addr - BASE_ADDR;
        sel_idx   = offset[IDX_W+1:2];
        sel_err   = 1'b0;
        if (!((sel_addr >= BASE_ADDR) && (offset < SPAN))) begin
            sel_err = 1'b1;
        end else if (offset[1:0] != 2'b00) begin
            sel_err = 1'b1;
        end else if (sel_write && (sel_idx < IDX_W'(2))) begin
            sel_err = 1'b1;
        end
        if (sel_idx == '0) begin
            sel_rdata = ID_VALUE;
        end else if (sel_idx == IDX_W'(1)) begin
            sel_rdata = DATA_WIDTH'({err_cnt_q, ok_cnt_q});
        end else begin
            sel_rdata = regs_q[sel_idx];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            ok_cnt_q  <= '0;
            err_cnt_q <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // Outputs are only non-zero during the single RESP cycle.
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (apb.PSEL && !apb.PENABLE) begin
                        addr_q  <= apb.PADDR;
                        write_q <= apb.PWRITE;
                        wdata_q <= apb.PWDATA;
                        err_q   <= sel_err;
                        if (WAIT_STATES == 0) begin
                            state_q   <= StResp;
                            pready_q  <= 1'b1;
                            pslverr_q <= sel_err;
                            prdata_q  <= (sel_err || apb.PWRITE) ? '0 : sel_rdata;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= WS_LOAD;
                        end
                    end
                end
                StWait: begin
                    if (!apb.PSEL) begin
                        state_q <= StIdle;
                    end else if (apb.PENABLE) begin
                        if (cnt_q == '0) begin
                            state_q   <= StResp;
                            pready_q  <= 1'b1;
                            pslverr_q <= err_q;
                            prdata_q  <= (err_q || write_q) ? '0 : sel_rdata;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    // Dropping PSEL here aborts: no commit, no count update.
                    if (apb.PSEL) begin
                        if (err_q) begin
                            if (err_cnt_q != 16'hFFFF) begin
                                err_cnt_q <= err_cnt_q + 16'd1;
                            end
                        end else begin
                            if (ok_cnt_q != 16'hFFFF) begin
                                ok_cnt_q <= ok_cnt_q + 16'd1;
                            end
                            if (write_q) begin
                                regs_q[sel_idx] <= wdata_q;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Self-checking bench for apb_regfile_slave: one DUT with the default two
// wait states and one with none, both checked against a register-map model.
module tb_apb_regfile_slave;

    localparam logic [31:0] ID    = 32'hA5B0_0001;
    localparam int          NREGS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel_v, penable_v, pwrite_v;
    logic [31:0] paddr_v, pwdata_v;
    int          sel;
    logic [31:0] obs_prdata;
    logic        obs_pready, obs_pslverr;

    always #5 clk = ~clk;

    apb_regfile_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    apb_regfile_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

    assign bus0.PSEL    = (sel == 0) ? psel_v : 1'b0;
    assign bus0.PENABLE = penable_v;
    assign bus0.PWRITE  = pwrite_v;
    assign bus0.PADDR   = paddr_v;
    assign bus0.PWDATA  = pwdata_v;
    assign bus1.PSEL    = (sel == 1) ? psel_v : 1'b0;
    assign bus1.PENABLE = penable_v;
    assign bus1.PWRITE  = pwrite_v;
    assign bus1.PADDR   = paddr_v;
    assign bus1.PWDATA  = pwdata_v;

    assign obs_prdata  = (sel == 0) ? bus0.PRDATA : bus1.PRDATA;
    assign obs_pready  = (sel == 0) ? bus0.PREADY : bus1.PREADY;
    assign obs_pslverr = (sel == 0) ? bus0.PSLVERR : bus1.PSLVERR;

    apb_regfile_slave #(.WAIT_STATES(2)) dut0 (.HCLK(clk), .HRESET(rst), .apb(bus0));
    apb_regfile_slave #(.WAIT_STATES(0)) dut1 (.HCLK(clk), .HRESET(rst), .apb(bus1));

    int total = 0;
    int bad   = 0;

    // Reference model: register contents and counters per DUT.
    logic [31:0] mregs [2][16];
    logic [15:0] okc [2];
    logic [15:0] errc [2];

    function automatic int ws_of(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) mregs[s][i] = 32'h0;
            okc[s]  = 16'h0;
            errc[s] = 16'h0;
        end
    endfunction

    function automatic void model_access(input int s, input bit wr, input logic [31:0] a,
                                         input logic [31:0] wd, output logic [31:0] rd,
                                         output bit er);
        bit inr;
        int idx;
        inr = (a >= 32'h100) && (a < 32'h100 + 32'(4 * NREGS));
        idx = inr ? int'((a - 32'h100) / 4) : 0;
        er  = !inr || (a % 4 != 0) || (wr && idx < 2);
        rd  = 32'h0;
        if (!er && !wr) begin
            if (idx == 0)      rd = ID;
            else if (idx == 1) rd = {errc[s], okc[s]};
            else               rd = mregs[s][idx];
        end
        if (!er && wr) mregs[s][idx] = wd;
        if (er) begin
            if (errc[s] != 16'hFFFF) errc[s] = errc[s] + 16'd1;
        end else begin
            if (okc[s] != 16'hFFFF) okc[s] = okc[s] + 16'd1;
        end
    endfunction

    // Runs one transfer starting in the current cycle (called just after an edge),
    // returns just after the completion edge with the bus idle.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output bit er, output int cyc,
                        output bit leak);
        bit got;
        got  = 1'b0;
        cyc  = 0;
        leak = 1'b0;
        rd   = 32'h0;
        er   = 1'b0;
        psel_v = 1'b1; penable_v = 1'b0; pwrite_v = wr; paddr_v = a; pwdata_v = wd;
        @(posedge clk); #1;
        penable_v = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (obs_pready) begin
                got = 1'b1; cyc = n; rd = obs_prdata; er = obs_pslverr;
            end else if (obs_prdata !== 32'h0 || obs_pslverr !== 1'b0) begin
                leak = 1'b1;
            end
            @(posedge clk); #1;
            if (got) break;
        end
        psel_v = 1'b0; penable_v = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sel = 0;
        psel_v = 1'b0; penable_v = 1'b0; pwrite_v = 1'b0; paddr_v = 32'h0; pwdata_v = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if (bus0.PREADY !== 1'b0 || bus0.PSLVERR !== 1'b0 || bus0.PRDATA !== 32'h0) begin
            bad++;
            $display("FAIL reset_dut0 got rdy=%b err=%b rd=%h want 0/0/0",
                     bus0.PREADY, bus0.PSLVERR, bus0.PRDATA);
        end
        total++;
        if (bus1.PREADY !== 1'b0 || bus1.PSLVERR !== 1'b0 || bus1.PRDATA !== 32'h0) begin
            bad++;
            $display("FAIL reset_dut1 got rdy=%b err=%b rd=%h want 0/0/0",
                     bus1.PREADY, bus1.PSLVERR, bus1.PRDATA);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd, mrd;
        bit er, mer, leak;
        int cyc;
        sel = 0;
        xfer(1'b1, 32'h108, 32'hDEAD_BEEF, rd, er, cyc, leak);
        model_access(0, 1'b1, 32'h108, 32'hDEAD_BEEF, mrd, mer);
        total++;
        if (cyc !== 3 || er !== 1'b0 || leak) begin
            bad++;
            $display("FAIL wr108 got cyc=%0d err=%b leak=%b want cyc=3 err=0 leak=0",
                     cyc, er, leak);
        end
        xfer(1'b0, 32'h108, 32'h0, rd, er, cyc, leak);
        model_access(0, 1'b0, 32'h108, 32'h0, mrd, mer);
        total++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || cyc !== 3) begin
            bad++;
            $display("FAIL rd108 got %h err=%b cyc=%0d want deadbeef err=0 cyc=3", rd, er, cyc);
        end
        xfer(1'b0, 32'h104, 32'h0, rd, er, cyc, leak);
        model_access(0, 1'b0, 32'h104, 32'h0, mrd, mer);
        total++;
        if (rd !== 32'h0000_0002 || rd !== mrd) begin
            bad++;
            $display("FAIL status_after_2 got %h want 00000002", rd);
        end
    endtask

    task automatic test_id();
        logic [31:0] rd, mrd;
        bit er, mer, leak;
        int cyc;
        sel = 0;
        xfer(1'b0, 32'h100, 32'h0, rd, er, cyc, leak);
        model_access(0, 1'b0, 32'h100, 32'h0, mrd, mer);
        total++;
        if (rd !== ID || er !== 1'b0) begin
            bad++;
            $display("FAIL id_read got %h err=%b want %h err=0", rd, er, ID);
        end
        xfer(1'b1, 32'h100, 32'h1234, rd, er, cyc, leak);
        model_access(0, 1'b1, 32'h100, 32'h1234, mrd, mer);
        total++;
        if (er !== 1'b1 || rd !== 32'h0 || cyc !== 3) begin
            bad++;
            $display("FAIL id_write got err=%b rd=%h cyc=%0d want err=1 rd=0 cyc=3", er, rd, cyc);
        end
        xfer(1'b0, 32'h100, 32'h0, rd, er, cyc, leak);
        model_access(0, 1'b0, 32'h100, 32'h0, mrd, mer);
        total++;
        if (rd !== ID) begin
            bad++;
            $display("FAIL id_reread got %h want %h", rd, ID);
        end
    endtask

    task automatic test_decode_err();
        logic [31:0] rd, mrd, s0;
        bit er, mer, leak;
        int cyc;
        sel = 0;
        xfer(1'b0, 32'h104, 32'h0, s0, er, cyc, leak);
        model_access(0, 1'b0, 32'h104, 32'h0, mrd, mer);
        total++;
        if (s0 !== mrd) begin
            bad++;
            $display("FAIL status_pre got %h want %h", s0, mrd);
        end
        xfer(1'b0, 32'h120, 32'h0, rd, er, cyc, leak);
        model_access(0, 1'b0, 32'h120, 32'h0, mrd, mer);
        total++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            bad++;
            $display("FAIL oob_120 got err=%b rd=%h want err=1 rd=0", er, rd);
        end
        xfer(1'b1, 32'h10A, 32'h5555_AAAA, rd, er, cyc, leak);
        model_access(0, 1'b1, 32'h10A, 32'h5555_AAAA, mrd, mer);
        total++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            bad++;
            $display("FAIL misalign_10a got err=%b rd=%h want err=1 rd=0", er, rd);
        end
        xfer(1'b0, 32'h104, 32'h0, rd, er, cyc, leak);
        model_access(0, 1'b0, 32'h104, 32'h0, mrd, mer);
        total++;
        if (rd[31:16] !== s0[31:16] + 16'd2 || rd !== mrd) begin
            bad++;
            $display("FAIL err_count got %h want %h", rd, mrd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, mrd;
        logic [31:0] c1, c2;
        bit er, mer, leak;
        int cyc1, cyc2, cyc;
        sel = 1;
        c1 = $urandom; c2 = $urandom;
        xfer(1'b1, 32'h10C, c1, rd, er, cyc1, leak);
        model_access(1, 1'b1, 32'h10C, c1, mrd, mer);
        xfer(1'b1, 32'h110, c2, rd, er, cyc2, leak);
        model_access(1, 1'b1, 32'h110, c2, mrd, mer);
        total++;
        if (cyc1 !== 1 || cyc2 !== 1) begin
            bad++;
            $display("FAIL b2b_latency got %0d,%0d want 1,1", cyc1, cyc2);
        end
        xfer(1'b0, 32'h10C, 32'h0, rd, er, cyc, leak);
        model_access(1, 1'b0, 32'h10C, 32'h0, mrd, mer);
        total++;
        if (rd !== c1) begin
            bad++;
            $display("FAIL b2b_reg10c got %h want %h", rd, c1);
        end
        xfer(1'b0, 32'h110, 32'h0, rd, er, cyc, leak);
        model_access(1, 1'b0, 32'h110, 32'h0, mrd, mer);
        total++;
        if (rd !== c2) begin
            bad++;
            $display("FAIL b2b_reg110 got %h want %h", rd, c2);
        end
    endtask

    task automatic test_ignore_enable();
        bit seen;
        sel = 0;
        seen = 1'b0;
        psel_v = 1'b1; penable_v = 1'b1; pwrite_v = 1'b1; paddr_v = 32'h11C; pwdata_v = 32'h77;
        repeat (6) begin
            @(negedge clk);
            if (obs_pready !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        psel_v = 1'b0; penable_v = 1'b0;
        total++;
        if (seen) begin
            bad++;
            $display("FAIL enable_in_idle got pready=1 want 0");
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, mrd;
        bit er, mer, leak, seen;
        int cyc;
        sel = 0;
        seen = 1'b0;
        psel_v = 1'b1; penable_v = 1'b0; pwrite_v = 1'b1; paddr_v = 32'h114;
        pwdata_v = 32'hCAFE_F00D;
        @(posedge clk); #1 penable_v = 1'b1;
        @(negedge clk);
        if (obs_pready !== 1'b0) seen = 1'b1;
        @(posedge clk); #1 psel_v = 1'b0; penable_v = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (obs_pready !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abort_pready got pready=1 want 0");
        end
        xfer(1'b0, 32'h114, 32'h0, rd, er, cyc, leak);
        model_access(0, 1'b0, 32'h114, 32'h0, mrd, mer);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL abort_reg114 got %h want 0", rd);
        end
        xfer(1'b0, 32'h104, 32'h0, rd, er, cyc, leak);
        model_access(0, 1'b0, 32'h104, 32'h0, mrd, mer);
        total++;
        if (rd !== mrd) begin
            bad++;
            $display("FAIL abort_status got %h want %h", rd, mrd);
        end
    endtask

    task automatic test_reset_resp();
        logic [31:0] rd, mrd;
        bit er, mer, leak, got;
        int cyc;
        sel = 0;
        got = 1'b0;
        psel_v = 1'b1; penable_v = 1'b0; pwrite_v = 1'b1; paddr_v = 32'h118;
        pwdata_v = 32'h1357_9BDF;
        @(posedge clk); #1 penable_v = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (obs_pready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL rst_resp_timeout got no pready want pready");
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; psel_v = 1'b0; penable_v = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if (obs_pready !== 1'b0 || obs_pslverr !== 1'b0 || obs_prdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_resp_outputs got rdy=%b err=%b rd=%h want 0/0/0",
                     obs_pready, obs_pslverr, obs_prdata);
        end
        @(posedge clk); #1;
        xfer(1'b0, 32'h118, 32'h0, rd, er, cyc, leak);
        model_access(0, 1'b0, 32'h118, 32'h0, mrd, mer);
        total++;
        if (rd !== 32'h0 || cyc !== 3) begin
            bad++;
            $display("FAIL rst_resp_reg118 got %h cyc=%0d want 0 cyc=3", rd, cyc);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, a, wd;
        bit er, mer, leak, wr;
        int cyc;
        for (int k = 0; k < 80; k++) begin
            sel = int'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            a   = 32'h0F8 + 32'($urandom_range(0, 50));
            if ($urandom_range(0, 3) != 0) a = {a[31:2], 2'b00};
            wd  = $urandom;
            xfer(wr, a, wd, rd, er, cyc, leak);
            model_access(sel, wr, a, wd, mrd, mer);
            total++;
            if (rd !== mrd || er !== mer || cyc !== ws_of(sel) + 1 || leak) begin
                bad++;
                $display("FAIL rand_%0d dut%0d %s a=%h got rd=%h err=%b cyc=%0d leak=%b want rd=%h err=%b cyc=%0d",
                         k, sel, wr ? "wr" : "rd", a, rd, er, cyc, leak, mrd, mer,
                         ws_of(sel) + 1);
            end
            if ($urandom_range(0, 1) != 0) begin
                @(negedge clk);
                total++;
                if (obs_pready !== 1'b0 || obs_prdata !== 32'h0) begin
                    bad++;
                    $display("FAIL rand_idle_%0d got rdy=%b rd=%h want 0/0",
                             k, obs_pready, obs_prdata);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_id();
        test_decode_err();
        test_back_to_back();
        test_ignore_enable();
        test_abort();
        test_reset_resp();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
